// File: rtl/fp_mult_pkg.sv
// Shared types and helpers for the parametrised floating-point multiplier.
package fp_mult_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_NORM,
    ST_ROUND,
    ST_DONE
  } state_t;

  localparam int DEF_EXP_W = 4;
  localparam int DEF_MAN_W = 8;

  function automatic int fp_w(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  function automatic int exp_max(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  localparam logic [DEF_EXP_W-1:0] EXP_ONES = '1;
  localparam logic [fp_w(DEF_EXP_W, DEF_MAN_W)-1:0] INVALID_ENC =
    {1'b0, {DEF_EXP_W{1'b1}}, {DEF_MAN_W{1'b1}}};

endpackage

// File: rtl/fp_mult_param_round.sv
// Round-to-nearest-even on a stored mantissa plus guard/round/sticky bits.
module fp_round_rne
  import fp_mult_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W
) (
  input  logic [MAN_W-1:0]        mant,
  input  logic                    guard_bit,
  input  logic                    round_bit,
  input  logic                    sticky_bit,
  input  logic signed [EXP_W+1:0] e_in,
  output logic [MAN_W-1:0]        mant_out,
  output logic signed [EXP_W+1:0] e_out,
  output logic                    carry,
  output logic                    inexact
);

  logic             round_up;
  logic [MAN_W:0]   sum;

  always_comb begin
    inexact  = guard_bit | round_bit | sticky_bit;
    round_up = guard_bit & (round_bit | sticky_bit | mant[0]);
    sum      = {1'b0, mant} + {{MAN_W{1'b0}}, round_up};
    carry    = sum[MAN_W];
    mant_out = sum[MAN_W-1:0];
    // Carry out of the stored mantissa also lifts a subnormal into the normal range.
    e_out    = e_in + $signed({{(EXP_W+1){1'b0}}, carry});
  end

endmodule

// File: rtl/fp_mult_param.sv
// Multi-cycle sign/exponent/mantissa multiplier with denormals, RNE rounding and IEEE-style flags.
module fp_mult_param
  import fp_mult_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W,
  parameter int BIAS  = 2**(EXP_W-1) - 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [fp_w(EXP_W, MAN_W)-1:0]   a,
  input  logic [fp_w(EXP_W, MAN_W)-1:0]   b,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [fp_w(EXP_W, MAN_W)-1:0]   y,
  output logic                            overflow,
  output logic                            underflow,
  output logic                            inexact,
  output logic                            invalid
);

  localparam int W  = fp_w(EXP_W, MAN_W);
  localparam int SW = MAN_W + 1;
  localparam int PW = 2 * SW;
  localparam int EW = EXP_W + 2;

  localparam logic signed [EW-1:0] E_ONE  = EW'(1);
  localparam logic signed [EW-1:0] E_BIAS = EW'(BIAS);
  localparam logic signed [EW-1:0] E_INF  = EW'(exp_max(EXP_W));
  localparam logic signed [EW-1:0] E_CAP  = EW'(MAN_W + 2);
  localparam logic [EXP_W-1:0]     EXP_ALL1 = '1;
  localparam logic [MAN_W-1:0]     MAN_ALL1 = '1;
  localparam logic [PW-2:0]        LOW_ONES = '1;

  state_t state, state_nx;

  logic [W-1:0]          a_r, b_r;
  logic                  sign_r;
  logic [PW-1:0]         prod_r;
  logic signed [EW-1:0]  e_r;
  logic                  stk_r;

  logic                  accept;
  logic [EXP_W-1:0]      ea, eb;
  logic [MAN_W-1:0]      ma, mb;
  logic                  sa, sb;
  logic                  a_inf, b_inf, a_zero, b_zero, special;
  logic [PW-1:0]         prod_mul;
  logic signed [EW-1:0]  eff_a, eff_b, e_mul;

  logic signed [EW-1:0]  sh_raw;
  logic [EW-1:0]         sh;
  logic [PW-2:0]         shifted;
  logic                  lost, hidden;
  logic [MAN_W-1:0]      mant_pre, mant_rnd;
  logic                  g_bit, r_bit, s_bit;
  logic signed [EW-1:0]  e_pre, e_rnd;
  logic                  rnd_carry, rnd_inexact, ovf;

  assign in_ready = (state == ST_IDLE) & ~rst;
  assign accept   = in_valid & in_ready;

  assign sa = a_r[W-1];
  assign sb = b_r[W-1];
  assign ea = a_r[MAN_W +: EXP_W];
  assign eb = b_r[MAN_W +: EXP_W];
  assign ma = a_r[MAN_W-1:0];
  assign mb = b_r[MAN_W-1:0];

  assign a_inf   = &ea;
  assign b_inf   = &eb;
  assign a_zero  = (ea == '0) && (ma == '0);
  assign b_zero  = (eb == '0) && (mb == '0);
  assign special = a_inf | b_inf | a_zero | b_zero;

  assign prod_mul = {{SW{1'b0}}, |ea, ma} * {{SW{1'b0}}, |eb, mb};
  assign eff_a    = (ea == '0) ? E_ONE : $signed({2'b00, ea});
  assign eff_b    = (eb == '0) ? E_ONE : $signed({2'b00, eb});
  assign e_mul    = eff_a + eff_b - E_BIAS;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (accept) state_nx = ST_MUL;
      ST_MUL:   state_nx = special ? ST_DONE : ST_NORM;
      ST_NORM:  if (prod_r[PW-1] || prod_r[PW-2] || !(e_r > E_ONE)) state_nx = ST_ROUND;
      ST_ROUND: state_nx = ST_DONE;
      ST_DONE:  if (out_ready) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Denormalise into the subnormal range; the MSB is always clear here after NORM.
  always_comb begin
    sh_raw = '0;
    sh     = '0;
    if (e_r < E_ONE) begin
      sh_raw = E_ONE - e_r;
      sh     = (sh_raw > E_CAP) ? E_CAP : sh_raw;
    end
    shifted  = prod_r[PW-2:0] >> sh;
    lost     = |(prod_r[PW-2:0] & ~(LOW_ONES << sh));
    hidden   = shifted[PW-2];
    mant_pre = shifted[PW-3 -: MAN_W];
    g_bit    = shifted[MAN_W-1];
    r_bit    = shifted[MAN_W-2];
    s_bit    = (|shifted[MAN_W-3:0]) | lost | stk_r;
    e_pre    = hidden ? e_r : '0;
  end

  fp_round_rne #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
    .mant       (mant_pre),
    .guard_bit  (g_bit),
    .round_bit  (r_bit),
    .sticky_bit (s_bit),
    .e_in       (e_pre),
    .mant_out   (mant_rnd),
    .e_out      (e_rnd),
    .carry      (rnd_carry),
    .inexact    (rnd_inexact)
  );

  assign ovf = (e_rnd >= E_INF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r       <= '0;
      b_r       <= '0;
      sign_r    <= 1'b0;
      prod_r    <= '0;
      e_r       <= '0;
      stk_r     <= 1'b0;
      y         <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      inexact   <= 1'b0;
      invalid   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: if (accept) begin
          a_r       <= a;
          b_r       <= b;
          overflow  <= 1'b0;
          underflow <= 1'b0;
          inexact   <= 1'b0;
          invalid   <= 1'b0;
        end
        ST_MUL: begin
          sign_r <= sa ^ sb;
          prod_r <= prod_mul;
          e_r    <= e_mul;
          stk_r  <= 1'b0;
          if (special) begin
            out_valid <= 1'b1;
            if (a_inf | b_inf) begin
              invalid <= a_zero | b_zero;
              y       <= {sa ^ sb, EXP_ALL1, (a_zero | b_zero) ? MAN_ALL1 : '0};
            end else begin
              y <= {sa ^ sb, {(W-1){1'b0}}};
            end
          end
        end
        ST_NORM: begin
          if (prod_r[PW-1]) begin
            prod_r <= prod_r >> 1;
            stk_r  <= stk_r | prod_r[0];
            e_r    <= e_r + E_ONE;
          end else if (!prod_r[PW-2] && (e_r > E_ONE)) begin
            prod_r <= prod_r << 1;
            e_r    <= e_r - E_ONE;
          end
        end
        ST_ROUND: begin
          out_valid <= 1'b1;
          if (ovf) begin
            y         <= {sign_r, EXP_ALL1, {MAN_W{1'b0}}};
            overflow  <= 1'b1;
            underflow <= 1'b0;
            inexact   <= 1'b1;
          end else begin
            y         <= {sign_r, e_rnd[EXP_W-1:0], mant_rnd};
            overflow  <= 1'b0;
            underflow <= ~(|e_pre) & ~rnd_carry;
            inexact   <= rnd_inexact;
          end
        end
        ST_DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
